cyq_tt_checker: RTL and testbench

CYQ_TT_CHECKER -- requirements
Module: cyq_tt_checker

---
 rtl/cyq_tt_checker_if.sv | 24 ++
 rtl/cyq_tt_checker.sv | 97 +++++++++
 tb/tb_cyq_tt_checker.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cyq_tt_checker_if.sv
// Stimulus/response and status bundle for the 3-input truth-table checker.
// The slave modport is the checker; the master modport is the environment
// that issues START and returns the function output Y.
interface cyq_tt_checker_if;
  logic       start;
  logic       y;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_mask;

  modport master (
    output start, y,
    input  a, b, c, busy, done, pass, err_mask
  );

  modport slave (
    input  start, y,
    output a, b, c, busy, done, pass, err_mask
  );
endinterface

// File: rtl/cyq_tt_checker.sv
// Exhaustive checker for a 3-input combinational function.
// Sweeps {A,B,C} through 000..111, holds each vector SETTLE+1 cycles and
// compares Y on the last cycle of the window against EXPECT[index].
//
// state | meaning
// IDLE  | waiting for START, stimulus parked at 000
// RUN   | sweep in progress, stimulus = idx
// DONE  | sweep finished, result held until next START or reset
module cyq_tt_checker #(
  parameter logic [7:0] EXPECT = 8'hE8,
  parameter int         SETTLE = 2
) (
  input logic           clk,
  input logic           rst,
  cyq_tt_checker_if.slave bus
);

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic [2:0] abc_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] err_mask_q;

  // Sequencer: stimulus stepping, settle timing, result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= 3'd0;
      cnt        <= 4'd0;
      abc_q      <= 3'b000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_mask_q <= 8'h00;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state      <= S_RUN;
            idx        <= 3'd0;
            cnt        <= 4'd0;
            abc_q      <= 3'b000;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_mask_q <= 8'h00;
          end
        end
        S_RUN: begin
          if (cnt == SETTLE_W) begin
            cnt <= 4'd0;
            if (bus.y != EXPECT[idx]) begin
              err_mask_q[idx] <= 1'b1;
            end
            if (idx == 3'd7) begin
              state  <= S_DONE;
              idx    <= 3'd0;
              abc_q  <= 3'b000;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              idx   <= idx + 3'd1;
              abc_q <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state  <= S_IDLE;
          idx    <= 3'd0;
          cnt    <= 4'd0;
          abc_q  <= 3'b000;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a        = abc_q[2];
  assign bus.b        = abc_q[1];
  assign bus.c        = abc_q[0];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err_mask = err_mask_q;
  assign bus.pass     = done_q && (err_mask_q == 8'h00);

endmodule

// File: tb/tb_cyq_tt_checker.sv
// Directed bench for cyq_tt_checker: one instance with SETTLE=2 and a
// selectable Y model, one with SETTLE=1 whose Y glitches on the first cycle
// of every vector window.
module tb_cyq_tt_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cyq_tt_checker_if bus1 ();
  cyq_tt_checker_if bus2 ();

  cyq_tt_checker #(.EXPECT(8'hE8), .SETTLE(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  cyq_tt_checker #(.EXPECT(8'hE8), .SETTLE(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_checks = 0;
  int n_errors = 0;

  // 0: majority, 1: tied 0, 2: majority with index 5 inverted, 3: tied 1
  logic [1:0] mode1;
  logic [2:0] abc1, abc2, prev_abc2;
  logic       prev_busy2, glitch2;

  function automatic logic maj(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  assign abc1 = {bus1.a, bus1.b, bus1.c};
  assign abc2 = {bus2.a, bus2.b, bus2.c};
  assign bus1.y = (mode1 == 2'd0) ? maj(abc1) :
                  (mode1 == 2'd1) ? 1'b0 :
                  (mode1 == 2'd2) ? (maj(abc1) ^ (abc1 == 3'd5)) : 1'b1;

  // Track the previous cycle's stimulus to detect the first cycle of a window.
  always @(posedge clk) begin
    prev_abc2  <= abc2;
    prev_busy2 <= bus2.busy;
  end
  assign glitch2 = bus2.busy && (!prev_busy2 || (abc2 != prev_abc2));
  assign bus2.y  = maj(abc2) ^ glitch2;

  task automatic sweep1(input logic [7:0] exp_mask, input string nm);
    @(negedge clk); bus1.start = 1'b1;
    @(posedge clk); #1; bus1.start = 1'b0;
    n_checks++;
    if (bus1.busy !== 1'b1 || bus1.done !== 1'b0 || bus1.err_mask !== 8'h00 || abc1 !== 3'd0) begin
      n_errors++;
      $display("FAIL %s_start: busy=%b done=%b err=%h abc=%0d, want 1 0 00 0", nm, bus1.busy, bus1.done, bus1.err_mask, abc1);
    end
    for (int k = 1; k < 24; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (abc1 !== 3'(k / 3) || bus1.busy !== 1'b1 || bus1.done !== 1'b0 || bus1.pass !== 1'b0) begin
        n_errors++;
        $display("FAIL %s_edge%0d: abc=%0d busy=%b done=%b pass=%b, want abc=%0d 1 0 0", nm, k, abc1, bus1.busy, bus1.done, bus1.pass, k / 3);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus1.done !== 1'b1 || bus1.busy !== 1'b0 || abc1 !== 3'd0) begin
      n_errors++;
      $display("FAIL %s_done24: done=%b busy=%b abc=%0d, want 1 0 0", nm, bus1.done, bus1.busy, abc1);
    end
    n_checks++;
    if (bus1.err_mask !== exp_mask) begin
      n_errors++;
      $display("FAIL %s_err_mask: got %h want %h", nm, bus1.err_mask, exp_mask);
    end
    n_checks++;
    if (bus1.pass !== (exp_mask == 8'h00)) begin
      n_errors++;
      $display("FAIL %s_pass: got %b want %b", nm, bus1.pass, (exp_mask == 8'h00));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus1.start = 1'b1; bus2.start = 1'b1; mode1 = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.pass !== 1'b0 || bus1.err_mask !== 8'h00 || abc1 !== 3'd0) begin
      n_errors++;
      $display("FAIL reset1: busy=%b done=%b pass=%b err=%h abc=%0d, want all 0", bus1.busy, bus1.done, bus1.pass, bus1.err_mask, abc1);
    end
    n_checks++;
    if (bus2.busy !== 1'b0 || bus2.done !== 1'b0 || bus2.pass !== 1'b0 || bus2.err_mask !== 8'h00 || abc2 !== 3'd0) begin
      n_errors++;
      $display("FAIL reset2: busy=%b done=%b pass=%b err=%h abc=%0d, want all 0", bus2.busy, bus2.done, bus2.pass, bus2.err_mask, abc2);
    end
    bus1.start = 1'b0; bus2.start = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus1.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: busy=%b want 0", bus1.busy);
    end
  endtask

  task automatic test_majority();
    mode1 = 2'd0;
    sweep1(8'h00, "majority");
  endtask

  task automatic test_tied_zero();
    mode1 = 2'd1;
    sweep1(8'hE8, "tied_zero");
  endtask

  task automatic test_index5();
    mode1 = 2'd2;
    sweep1(8'h20, "index5");
  endtask

  task automatic test_reset_abort();
    mode1 = 2'd3;
    @(negedge clk); bus1.start = 1'b1;
    @(posedge clk); #1; bus1.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    n_checks++;
    if (bus1.busy !== 1'b1 || bus1.err_mask !== 8'h07) begin
      n_errors++;
      $display("FAIL abort_pre: busy=%b err=%h, want 1 07", bus1.busy, bus1.err_mask);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    n_checks++;
    if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.err_mask !== 8'h00 || abc1 !== 3'd0 || bus1.pass !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_post: busy=%b done=%b err=%h abc=%0d pass=%b, want all 0", bus1.busy, bus1.done, bus1.err_mask, abc1, bus1.pass);
    end
    mode1 = 2'd0;
    sweep1(8'h00, "post_abort");
  endtask

  task automatic test_back_to_back();
    logic       done_exp;
    logic [2:0] idx_exp;
    mode1 = 2'd0;
    @(negedge clk); bus1.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 75; k++) begin
      @(posedge clk); #1;
      done_exp = (k == 24) || (k == 49) || (k >= 74);
      if (k < 24)      idx_exp = 3'(k / 3);
      else if (k < 25) idx_exp = 3'd0;
      else if (k < 49) idx_exp = 3'((k - 25) / 3);
      else if (k < 50) idx_exp = 3'd0;
      else if (k < 74) idx_exp = 3'((k - 50) / 3);
      else             idx_exp = 3'd0;
      n_checks++;
      if (bus1.done !== done_exp || bus1.busy !== !done_exp || abc1 !== idx_exp ||
          bus1.pass !== done_exp || bus1.err_mask !== 8'h00) begin
        n_errors++;
        $display("FAIL b2b_edge%0d: done=%b busy=%b abc=%0d pass=%b err=%h, want done=%b abc=%0d err=00",
                 k, bus1.done, bus1.busy, abc1, bus1.pass, bus1.err_mask, done_exp, idx_exp);
      end
      if (k == 60) bus1.start = 1'b0;
    end
  endtask

  task automatic test_settle1();
    @(negedge clk); bus2.start = 1'b1;
    @(posedge clk); #1; bus2.start = 1'b0;
    for (int k = 1; k < 16; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (abc2 !== 3'(k / 2) || bus2.busy !== 1'b1 || bus2.done !== 1'b0) begin
        n_errors++;
        $display("FAIL settle1_edge%0d: abc=%0d busy=%b done=%b, want abc=%0d 1 0", k, abc2, bus2.busy, bus2.done, k / 2);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus2.done !== 1'b1 || bus2.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL settle1_done16: done=%b busy=%b, want 1 0", bus2.done, bus2.busy);
    end
    n_checks++;
    if (bus2.err_mask !== 8'h00 || bus2.pass !== 1'b1) begin
      n_errors++;
      $display("FAIL settle1_result: err=%h pass=%b, want 00 1", bus2.err_mask, bus2.pass);
    end
  endtask

  initial begin
    test_reset();
    test_majority();
    test_tied_zero();
    test_index5();
    test_reset_abort();
    test_back_to_back();
    test_settle1();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
